// File: rtl/mem_responder_if.sv
// mem_responder_if: strobe-protocol memory bus; master drives addr/data_in/write/read/clear_req, slave returns data_out/rd_valid/busy/err/wr_count/rd_count
interface mem_responder_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
);
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data_in;
  logic              write;
  logic              read;
  logic              clear_req;
  logic [DATA_W-1:0] data_out;
  logic              rd_valid;
  logic              busy;
  logic              err;
  logic [CNT_W-1:0]  wr_count;
  logic [CNT_W-1:0]  rd_count;
  modport master (
    output addr, data_in, write, read, clear_req,
    input  data_out, rd_valid, busy, err, wr_count, rd_count
  );
  modport slave (
    input  addr, data_in, write, read, clear_req,
    output data_out, rd_valid, busy, err, wr_count, rd_count
  );
endinterface

// File: rtl/mem_responder.sv
// mem_responder: 2**ADDR_W x DATA_W sync RAM with registered read valid, sticky protocol err, clear sweep (busy) and saturating wr/rd counters; ports clk, rst_n, bus (mem_responder_if.slave)
module mem_responder #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
) (
  input logic             clk,
  input logic             rst_n,
  mem_responder_if.slave  bus
);
  typedef enum logic {IDLE, CLEAR} state_t;
  state_t            state, state_d;
  logic [ADDR_W-1:0] ptr, ptr_d;
  logic [DATA_W-1:0] mem [0:2**ADDR_W-1];
  logic [DATA_W-1:0] data_out;
  logic              rd_valid, err;
  logic [CNT_W-1:0]  wr_count, rd_count;
  logic              wr_acc, rd_acc, err_set, mem_we;
  logic [ADDR_W-1:0] mem_wa;
  logic [DATA_W-1:0] mem_wd;
  always_comb begin
    state_d = state;
    ptr_d   = ptr;
    wr_acc  = 1'b0;
    rd_acc  = 1'b0;
    err_set = bus.read | bus.write;
    if (state == IDLE) begin
      if (bus.clear_req) begin
        state_d = CLEAR;
        ptr_d   = '0;
      end else if (!(bus.read && bus.write)) begin
        wr_acc  = bus.write;
        rd_acc  = bus.read;
        err_set = 1'b0;
      end
    end else begin
      ptr_d   = ptr + 1'b1;
      state_d = ptr == '1 ? IDLE : CLEAR;
    end
  end
  assign mem_we = wr_acc | (state == CLEAR);
  assign mem_wa = state == CLEAR ? ptr : bus.addr;
  assign mem_wd = state == CLEAR ? '0 : bus.data_in;
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_wa] <= mem_wd;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      ptr      <= '0;
      data_out <= '0;
      rd_valid <= 1'b0;
      err      <= 1'b0;
      wr_count <= '0;
      rd_count <= '0;
    end else begin
      state    <= state_d;
      ptr      <= ptr_d;
      rd_valid <= rd_acc;
      err      <= err | err_set;
      if (rd_acc) data_out <= mem[bus.addr];
      if (wr_acc && wr_count != '1) wr_count <= wr_count + 1'b1;
      if (rd_acc && rd_count != '1) rd_count <= rd_count + 1'b1;
    end
  end
  assign bus.data_out = data_out;
  assign bus.rd_valid = rd_valid;
  assign bus.busy     = state == CLEAR;
  assign bus.err      = err;
  assign bus.wr_count = wr_count;
  assign bus.rd_count = rd_count;
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed self-checking bench for mem_responder (default and CNT_W=4 instances)
module tb_mem_responder;
  logic clk, rst_n;
  int checks, errors, nb;
  mem_responder_if #(.ADDR_W(5), .DATA_W(8), .CNT_W(16)) b ();
  mem_responder_if #(.ADDR_W(5), .DATA_W(8), .CNT_W(4))  s ();
  mem_responder #(.ADDR_W(5), .DATA_W(8), .CNT_W(16)) dut  (.clk(clk), .rst_n(rst_n), .bus(b));
  mem_responder #(.ADDR_W(5), .DATA_W(8), .CNT_W(4))  dut4 (.clk(clk), .rst_n(rst_n), .bus(s));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic wr(input logic [4:0] a, input logic [7:0] d);
    b.addr = a;
    b.data_in = d;
    b.write = 1'b1;
    cyc();
    b.write = 1'b0;
  endtask
  task automatic rd(input logic [4:0] a, input logic [7:0] exp);
    b.addr = a;
    b.read = 1'b1;
    cyc();
    b.read = 1'b0;
    chk("rd_valid", b.rd_valid, 1);
    chk("rd_data", b.data_out, exp);
    cyc();
    chk("rd_valid_drop", b.rd_valid, 0);
  endtask
  initial begin
    checks = 0;
    errors = 0;
    {b.addr, b.data_in, b.write, b.read, b.clear_req} = '0;
    {s.addr, s.data_in, s.write, s.read, s.clear_req} = '0;
    rst_n = 1'b0;
    #12;
    chk("rst_data_out", b.data_out, 0);
    chk("rst_rd_valid", b.rd_valid, 0);
    chk("rst_busy", b.busy, 0);
    chk("rst_err", b.err, 0);
    chk("rst_wr_count", b.wr_count, 0);
    chk("rst_rd_count", b.rd_count, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 32; i++) wr(5'(i), 8'h00);
    for (int i = 0; i < 32; i++) rd(5'(i), 8'h00);
    chk("wr_count_32", b.wr_count, 32);
    chk("rd_count_32", b.rd_count, 32);
    for (int i = 0; i < 32; i++) wr(5'(i), 8'(i));
    for (int i = 0; i < 32; i++) rd(5'(i), 8'(i));
    wr(5'd5, 8'h55);
    rd(5'd5, 8'h55);
    chk("wr_count_65", b.wr_count, 65);
    chk("rd_count_65", b.rd_count, 65);
    b.addr = 5'd3;
    b.data_in = 8'hAA;
    b.write = 1'b1;
    b.read = 1'b1;
    cyc();
    b.write = 1'b0;
    b.read = 1'b0;
    chk("both_err", b.err, 1);
    chk("both_rd_valid", b.rd_valid, 0);
    chk("both_data_hold", b.data_out, 8'h55);
    chk("both_wr_count", b.wr_count, 65);
    chk("both_rd_count", b.rd_count, 65);
    rd(5'd3, 8'h03);
    b.addr = 5'd31;
    b.data_in = 8'h11;
    b.write = 1'b1;
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_data_out", b.data_out, 0);
    chk("arst_err", b.err, 0);
    chk("arst_busy", b.busy, 0);
    chk("arst_wr_count", b.wr_count, 0);
    chk("arst_rd_count", b.rd_count, 0);
    b.write = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    wr(5'd31, 8'h5A);
    rd(5'd31, 8'h5A);
    for (int i = 0; i < 32; i++) wr(5'(i), 8'hFF);
    chk("pre_clear_err", b.err, 0);
    chk("pre_clear_wr_count", b.wr_count, 33);
    b.clear_req = 1'b1;
    cyc();
    b.clear_req = 1'b0;
    chk("clear_busy", b.busy, 1);
    nb = 0;
    for (int i = 0; i < 40; i++) begin
      nb += int'(b.busy);
      b.addr = 5'd7;
      b.data_in = 8'h77;
      b.write = (i == 10);
      cyc();
      b.write = 1'b0;
    end
    chk("busy_cycles", nb, 32);
    chk("clear_err", b.err, 1);
    chk("clear_wr_count", b.wr_count, 33);
    for (int i = 0; i < 32; i++) rd(5'(i), 8'h00);
    chk("post_clear_rd_count", b.rd_count, 33);
    for (int i = 0; i < 20; i++) begin
      s.addr = 5'(i);
      s.data_in = 8'(i);
      s.write = 1'b1;
      cyc();
      s.write = 1'b0;
      if (i == 13) chk("sat_14", s.wr_count, 14);
    end
    chk("sat_15", s.wr_count, 15);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
